// File: rtl/gpio_poll_master.sv
// gpio_poll_master: bus initiator for the single-register GPIO block.
// Services output-write commands and polls inputs, reporting changes.
module gpio_poll_master #(
    parameter logic [15:0] GPIO_ADDR = 16'hFFFF,
    parameter int unsigned POLL_DIV  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        m_wea,
    output logic [15:0] m_addr,
    output logic [31:0] m_din,
    input  logic [31:0] m_dout,
    input  logic        poll_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        evt_valid,
    input  logic        evt_ready,
    output logic [15:0] evt_data,
    output logic [15:0] evt_changed,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_REPORT
    } state_t;

    localparam logic [15:0] DIV_M1 = 16'(POLL_DIV - 1);

    state_t      state_q, state_d;
    logic [15:0] out_shadow_q, out_shadow_d;
    logic [15:0] last_in_q, last_in_d;
    logic [15:0] evt_data_q, evt_data_d;
    logic [15:0] evt_chg_q, evt_chg_d;
    logic [15:0] cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic        tick;
    logic [15:0] cur;
    logic        unused_dout;

    assign cur         = m_dout[31:16];
    assign unused_dout = ^m_dout[15:0];
    assign tick        = poll_en && (cnt_q == DIV_M1);

    // Poll timer: free-running while enabled; ticks collapse into one pending poll.
    always_comb begin
        cnt_d  = '0;
        pend_d = 1'b0;
        if (poll_en) begin
            cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
            pend_d = tick | (pend_q & (state_q != S_READ));
        end
    end

    // Next-state and bus/handshake outputs; commands win over a pending poll.
    always_comb begin
        state_d      = state_q;
        out_shadow_d = out_shadow_q;
        last_in_d    = last_in_q;
        evt_data_d   = evt_data_q;
        evt_chg_d    = evt_chg_q;
        m_wea        = 1'b0;
        m_din        = '0;
        cmd_ready    = 1'b0;
        evt_valid    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = !rst;
                if (cmd_valid) begin
                    out_shadow_d = cmd_data;
                    state_d      = S_WRITE;
                end else if (pend_q) begin
                    state_d = S_READ;
                end
            end
            S_WRITE: begin
                m_wea   = 1'b1;
                m_din   = {16'h0000, out_shadow_q};
                state_d = S_IDLE;
            end
            S_READ: begin
                if (cur != last_in_q) begin
                    evt_data_d = cur;
                    evt_chg_d  = cur ^ last_in_q;
                    last_in_d  = cur;
                    state_d    = S_REPORT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REPORT: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign m_addr      = GPIO_ADDR;
    assign evt_data    = evt_data_q;
    assign evt_changed = evt_chg_q;
    assign busy        = (state_q != S_IDLE);

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            out_shadow_q <= '0;
            last_in_q    <= '0;
            evt_data_q   <= '0;
            evt_chg_q    <= '0;
            cnt_q        <= '0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            out_shadow_q <= out_shadow_d;
            last_in_q    <= last_in_d;
            evt_data_q   <= evt_data_d;
            evt_chg_q    <= evt_chg_d;
            cnt_q        <= cnt_d;
            pend_q       <= pend_d;
        end
    end

endmodule
